// File: rtl/reg_commit_unit.sv
// In-order retirement buffer: tagged allocation, out-of-order writeback,
// in-order multi-lane commit, and a full flush when an excepting entry reaches head.
module reg_commit_unit #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 4,
    parameter int ALLOC_W  = 2,
    parameter int WB_W     = 2,
    parameter int COMMIT_W = 2,
    parameter int IDX_W    = 5,
    parameter int DATA_W   = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [ALLOC_W-1:0]           i_alloc_valid,
    input  logic [ALLOC_W-1:0]           i_alloc_has_dest,
    input  logic [ALLOC_W*IDX_W-1:0]     i_alloc_idx,
    output logic                         o_alloc_ready,
    output logic [ALLOC_W*TAG_W-1:0]     o_alloc_tag,
    input  logic [WB_W-1:0]              i_wb_valid,
    input  logic [WB_W*TAG_W-1:0]        i_wb_tag,
    input  logic [WB_W*DATA_W-1:0]       i_wb_data,
    input  logic [WB_W-1:0]              i_wb_except,
    output logic [COMMIT_W-1:0]          o_commit_valid,
    output logic [COMMIT_W*IDX_W-1:0]    o_commit_idx,
    output logic [COMMIT_W*DATA_W-1:0]   o_commit_data,
    output logic [1:0]                   o_retire_cnt,
    output logic                         o_recover,
    output logic                         o_empty
);

    localparam int PTR_W = TAG_W + 1;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_except;
    logic [DEPTH-1:0]  ent_has_dest;
    logic [IDX_W-1:0]  ent_idx  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  count;
    logic [TAG_W-1:0]  head_slot;
    logic              recover_pending;
    logic              alloc_ready;
    logic [PTR_W-1:0]  alloc_num;
    logic [PTR_W-1:0]  retire_num;
    logic [COMMIT_W-1:0] retire;
    logic              chain;
    logic [TAG_W-1:0]  alloc_slot  [ALLOC_W];
    logic [TAG_W-1:0]  commit_slot [COMMIT_W];

    always_comb begin
        count           = tail - head;
        head_slot       = head[TAG_W-1:0];
        recover_pending = ent_valid[head_slot] & ent_done[head_slot] & ent_except[head_slot];
        alloc_ready     = (count <= PTR_W'(DEPTH - ALLOC_W)) && !recover_pending && !o_recover;

        alloc_num   = '0;
        o_alloc_tag = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            alloc_slot[k] = tail[TAG_W-1:0] + TAG_W'(k);
            o_alloc_tag[k*TAG_W +: TAG_W] = alloc_slot[k];
            alloc_num = alloc_num + PTR_W'(i_alloc_valid[k]);
        end

        // Each lane retires only if every older lane retires too.
        chain          = 1'b1;
        retire         = '0;
        retire_num     = '0;
        o_commit_valid = '0;
        o_commit_idx   = '0;
        o_commit_data  = '0;
        for (int c = 0; c < COMMIT_W; c++) begin
            commit_slot[c] = head_slot + TAG_W'(c);
            retire[c] = chain & ent_valid[commit_slot[c]] & ent_done[commit_slot[c]]
                        & ~ent_except[commit_slot[c]];
            chain = retire[c];
            retire_num = retire_num + PTR_W'(retire[c]);
            o_commit_valid[c] = retire[c] & ent_has_dest[commit_slot[c]];
            o_commit_idx[c*IDX_W +: IDX_W]    = ent_idx[commit_slot[c]];
            o_commit_data[c*DATA_W +: DATA_W] = ent_data[commit_slot[c]];
        end

        o_retire_cnt = 2'(retire_num);
        o_empty      = (count == '0);
    end

    assign o_alloc_ready = alloc_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ent_valid  <= '0;
            ent_done   <= '0;
            ent_except <= '0;
            head       <= '0;
            tail       <= '0;
            o_recover  <= 1'b0;
        end else begin
            o_recover <= 1'b0;
            if (recover_pending) begin
                o_recover  <= 1'b1;
                ent_valid  <= '0;
                ent_done   <= '0;
                ent_except <= '0;
                head       <= '0;
                tail       <= '0;
            end else begin
                // Later ports overwrite earlier ones on a shared tag.
                if (!o_recover) begin
                    for (int p = 0; p < WB_W; p++) begin
                        if (i_wb_valid[p] && ent_valid[i_wb_tag[p*TAG_W +: TAG_W]]) begin
                            ent_done[i_wb_tag[p*TAG_W +: TAG_W]]   <= 1'b1;
                            ent_except[i_wb_tag[p*TAG_W +: TAG_W]] <= i_wb_except[p];
                            ent_data[i_wb_tag[p*TAG_W +: TAG_W]]   <= i_wb_data[p*DATA_W +: DATA_W];
                        end
                    end
                end
                for (int c = 0; c < COMMIT_W; c++) begin
                    if (retire[c]) begin
                        ent_valid[commit_slot[c]] <= 1'b0;
                        ent_done[commit_slot[c]]  <= 1'b0;
                    end
                end
                if (alloc_ready) begin
                    for (int k = 0; k < ALLOC_W; k++) begin
                        if (i_alloc_valid[k]) begin
                            ent_valid[alloc_slot[k]]    <= 1'b1;
                            ent_done[alloc_slot[k]]     <= 1'b0;
                            ent_except[alloc_slot[k]]   <= 1'b0;
                            ent_has_dest[alloc_slot[k]] <= i_alloc_has_dest[k];
                            ent_idx[alloc_slot[k]]      <= i_alloc_idx[k*IDX_W +: IDX_W];
                        end
                    end
                    tail <= tail + alloc_num;
                end
                head <= head + retire_num;
            end
        end
    end

endmodule

// File: tb/tb_reg_commit_unit.sv
// Bench for reg_commit_unit: directed scenarios plus randomized traffic
// checked against a program-order queue model.
module tb_reg_commit_unit;
    localparam int DEPTH = 16, TAG_W = 4, ALLOC_W = 2, WB_W = 2, COMMIT_W = 2, IDX_W = 5, DATA_W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ALLOC_W-1:0]          alloc_valid = '0, alloc_has_dest = '0;
    logic [ALLOC_W*IDX_W-1:0]    alloc_idx = '0;
    logic                        alloc_ready;
    logic [ALLOC_W*TAG_W-1:0]    alloc_tag;
    logic [WB_W-1:0]             wb_valid = '0, wb_except = '0;
    logic [WB_W*TAG_W-1:0]       wb_tag = '0;
    logic [WB_W*DATA_W-1:0]      wb_data = '0;
    logic [COMMIT_W-1:0]         commit_valid;
    logic [COMMIT_W*IDX_W-1:0]   commit_idx;
    logic [COMMIT_W*DATA_W-1:0]  commit_data;
    logic [1:0]                  retire_cnt;
    logic                        recover, empty;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reg_commit_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ALLOC_W(ALLOC_W), .WB_W(WB_W),
                      .COMMIT_W(COMMIT_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alloc_valid(alloc_valid), .i_alloc_has_dest(alloc_has_dest), .i_alloc_idx(alloc_idx),
        .o_alloc_ready(alloc_ready), .o_alloc_tag(alloc_tag),
        .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_data(wb_data), .i_wb_except(wb_except),
        .o_commit_valid(commit_valid), .o_commit_idx(commit_idx), .o_commit_data(commit_data),
        .o_retire_cnt(retire_cnt), .o_recover(recover), .o_empty(empty)
    );

    // Reference model: outstanding entries in program order.
    typedef struct {
        logic              has_dest;
        logic [IDX_W-1:0]  idx;
        logic              done;
        logic              exc;
        logic [DATA_W-1:0] data;
        int                tag;
    } ent_t;
    ent_t mq[$];
    int   m_next = 0;
    bit   m_rec = 1'b0;

    function automatic bit m_pending();
        return mq.size() > 0 && mq[0].done && mq[0].exc;
    endfunction

    function automatic bit m_ready();
        return (mq.size() <= DEPTH - ALLOC_W) && !m_pending() && !m_rec;
    endfunction

    function automatic int m_nret();
        int n = 0;
        while (n < COMMIT_W && n < mq.size() && mq[n].done && !mq[n].exc) n++;
        return n;
    endfunction

    task automatic model_step();
        bit rdy;
        int nret;
        if (!rst_n) begin
            mq.delete(); m_next = 0; m_rec = 1'b0;
            return;
        end
        if (m_pending()) begin
            mq.delete(); m_next = 0; m_rec = 1'b1;
            return;
        end
        rdy  = m_ready();
        nret = m_nret();
        if (!m_rec) begin
            for (int p = 0; p < WB_W; p++) begin
                if (wb_valid[p]) begin
                    foreach (mq[i]) begin
                        if (mq[i].tag == int'(wb_tag[p*TAG_W +: TAG_W])) begin
                            mq[i].done = 1'b1;
                            mq[i].exc  = wb_except[p];
                            mq[i].data = wb_data[p*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
        repeat (nret) void'(mq.pop_front());
        if (rdy) begin
            for (int k = 0; k < ALLOC_W; k++) begin
                if (alloc_valid[k]) begin
                    ent_t e;
                    e.has_dest = alloc_has_dest[k];
                    e.idx      = alloc_idx[k*IDX_W +: IDX_W];
                    e.done     = 1'b0;
                    e.exc      = 1'b0;
                    e.data     = '0;
                    e.tag      = m_next;
                    mq.push_back(e);
                    m_next = (m_next + 1) % DEPTH;
                end
            end
        end
        m_rec = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alloc_valid = '0; alloc_has_dest = '0; alloc_idx = '0;
        wb_valid = '0; wb_except = '0; wb_tag = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_idle();
        tick(); tick();
        rst_n = 1'b1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", empty); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", alloc_ready); end
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL reset_cvalid got=%b want=00", commit_valid); end
        total++; if (retire_cnt !== 2'd0) begin bad++; $display("FAIL reset_rcnt got=%0d want=0", retire_cnt); end
        total++; if (recover !== 1'b0) begin bad++; $display("FAIL reset_recover got=%0b want=0", recover); end
    endtask

    task automatic test_basic();
        alloc_valid = 2'b11; alloc_has_dest = 2'b11; alloc_idx = {5'd5, 5'd3};
        total++; if (alloc_tag !== {4'd1, 4'd0}) begin bad++; $display("FAIL basic_tags got=%h want=10", alloc_tag); end
        tick(); set_idle();
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd1}; wb_data = {64'h0, 64'hA};
        tick(); set_idle();
        total++; if (retire_cnt !== 2'd0) begin bad++; $display("FAIL basic_nocommit got=%0d want=0", retire_cnt); end
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd0}; wb_data = {64'h0, 64'hB};
        tick(); set_idle();
        total++; if (commit_valid !== 2'b11) begin bad++; $display("FAIL basic_cvalid got=%b want=11", commit_valid); end
        total++; if (commit_idx !== {5'd5, 5'd3}) begin bad++; $display("FAIL basic_idx got=%h want=%h", commit_idx, {5'd5, 5'd3}); end
        total++; if (commit_data !== {64'hA, 64'hB}) begin bad++; $display("FAIL basic_data got=%h", commit_data); end
        total++; if (retire_cnt !== 2'd2) begin bad++; $display("FAIL basic_rcnt got=%0d want=2", retire_cnt); end
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%0b want=1", empty); end
    endtask

    // Starts with head=tail=2, so the 16 tags run 2..15,0,1.
    task automatic test_fill_wrap();
        for (int i = 0; i < 8; i++) begin
            total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_ready i=%0d got=%0b want=1", i, alloc_ready); end
            alloc_valid = 2'b11; alloc_has_dest = 2'b11; alloc_idx = {5'(2*i+2), 5'(2*i+1)};
            tick();
        end
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", alloc_ready); end
        wb_valid = 2'b11; wb_tag = {4'd3, 4'd2}; wb_data = {64'h1001, 64'h1000};
        tick();
        wb_valid = '0;
        total++; if (retire_cnt !== 2'd2) begin bad++; $display("FAIL full_rcnt got=%0d want=2", retire_cnt); end
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready2 got=%0b want=0", alloc_ready); end
        tick(); set_idle();
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%0b want=1", alloc_ready); end
        for (int s = 2; s < 16; s += 2) begin
            wb_valid = 2'b11;
            wb_tag   = {4'((3 + s) % 16), 4'((2 + s) % 16)};
            wb_data  = {64'h1001 + 64'(s), 64'h1000 + 64'(s)};
            tick(); set_idle();
            total++; if (commit_valid !== 2'b11 || commit_idx !== {5'(s+2), 5'(s+1)} ||
                         commit_data !== {64'h1001 + 64'(s), 64'h1000 + 64'(s)}) begin
                bad++; $display("FAIL wrap_commit s=%0d got v=%b idx=%h data=%h", s, commit_valid, commit_idx, commit_data);
            end
            tick();
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0b want=1", empty); end
    endtask

    task automatic test_no_dest();
        alloc_valid = 2'b01; alloc_has_dest = 2'b00; alloc_idx = {5'd0, 5'd7};
        total++; if (alloc_tag[3:0] !== 4'd2) begin bad++; $display("FAIL nodest_tag got=%0d want=2", alloc_tag[3:0]); end
        tick(); set_idle();
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd2}; wb_data = {64'h0, 64'h55};
        tick(); set_idle();
        total++; if (retire_cnt !== 2'd1) begin bad++; $display("FAIL nodest_rcnt got=%0d want=1", retire_cnt); end
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL nodest_cvalid got=%b want=00", commit_valid); end
        tick();
        total++; if (empty !== 1'b1 || alloc_tag[3:0] !== 4'd3) begin bad++; $display("FAIL nodest_adv empty=%0b tag=%0d want 1,3", empty, alloc_tag[3:0]); end
    endtask

    task automatic test_except();
        rst_n = 1'b0; set_idle(); tick(); rst_n = 1'b1;
        alloc_valid = 2'b11; alloc_has_dest = 2'b11; alloc_idx = {5'd2, 5'd1};
        tick();
        alloc_valid = 2'b01; alloc_idx = {5'd0, 5'd3};
        tick(); set_idle();
        wb_valid = 2'b11; wb_tag = {4'd2, 4'd1}; wb_except = 2'b01; wb_data = {64'h22, 64'h11};
        tick(); set_idle();
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd0}; wb_data = {64'h0, 64'h77};
        tick(); set_idle();
        total++; if (retire_cnt !== 2'd1 || commit_valid !== 2'b01) begin bad++; $display("FAIL exc_first rcnt=%0d v=%b want 1,01", retire_cnt, commit_valid); end
        total++; if (commit_idx[4:0] !== 5'd1 || commit_data[63:0] !== 64'h77) begin bad++; $display("FAIL exc_first_val idx=%0d data=%h", commit_idx[4:0], commit_data[63:0]); end
        tick();
        total++; if (retire_cnt !== 2'd0 || commit_valid !== 2'b00 || recover !== 1'b0 || alloc_ready !== 1'b0) begin
            bad++; $display("FAIL exc_pending rcnt=%0d v=%b rec=%0b rdy=%0b want 0,00,0,0", retire_cnt, commit_valid, recover, alloc_ready);
        end
        tick();
        total++; if (recover !== 1'b1 || empty !== 1'b1 || alloc_ready !== 1'b0) begin
            bad++; $display("FAIL exc_pulse rec=%0b empty=%0b rdy=%0b want 1,1,0", recover, empty, alloc_ready);
        end
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd2}; wb_data = {64'h0, 64'h99};
        alloc_valid = 2'b11; alloc_has_dest = 2'b11;
        tick(); set_idle();
        total++; if (recover !== 1'b0 || empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_tag !== {4'd1, 4'd0}) begin
            bad++; $display("FAIL exc_after rec=%0b empty=%0b rdy=%0b tag=%h want 0,1,1,10", recover, empty, alloc_ready, alloc_tag);
        end
    endtask

    task automatic test_same_tag();
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 2'b11; alloc_has_dest = 2'b11; alloc_idx = {5'(2*i+11), 5'(2*i+10)};
            tick();
        end
        set_idle();
        wb_valid = 2'b11; wb_tag = {4'd1, 4'd0}; wb_data = {64'h1, 64'h0};
        tick();
        wb_tag = {4'd3, 4'd2};
        tick(); set_idle();
        tick();
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd9}; wb_data = {64'h0, 64'hDEAD};
        tick(); set_idle();
        total++; if (retire_cnt !== 2'd0 || empty !== 1'b0) begin bad++; $display("FAIL tag9_early rcnt=%0d empty=%0b want 0,0", retire_cnt, empty); end
        alloc_valid = 2'b11; alloc_has_dest = 2'b11; alloc_idx = {5'd17, 5'd16};
        tick();
        alloc_idx = {5'd19, 5'd18};
        tick(); set_idle();
        wb_valid = 2'b11; wb_tag = {4'd4, 4'd4}; wb_data = {64'h2, 64'h1};
        tick(); set_idle();
        total++; if (commit_valid !== 2'b01 || retire_cnt !== 2'd1) begin bad++; $display("FAIL same_tag_v v=%b rcnt=%0d want 01,1", commit_valid, retire_cnt); end
        total++; if (commit_data[63:0] !== 64'h2 || commit_idx[4:0] !== 5'd14) begin bad++; $display("FAIL same_tag_data data=%h idx=%0d want 2,14", commit_data[63:0], commit_idx[4:0]); end
        tick();
        wb_valid = 2'b11; wb_tag = {4'd6, 4'd5}; wb_data = {64'h6, 64'h5};
        tick();
        wb_tag = {4'd8, 4'd7}; wb_data = {64'h8, 64'h7};
        tick(); set_idle();
        tick();
        total++; if (retire_cnt !== 2'd0 || empty !== 1'b0) begin bad++; $display("FAIL tag9_ignored rcnt=%0d empty=%0b want 0,0", retire_cnt, empty); end
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd9}; wb_data = {64'h0, 64'h99};
        tick(); set_idle();
        total++; if (commit_valid !== 2'b01 || commit_data[63:0] !== 64'h99 || commit_idx[4:0] !== 5'd19) begin
            bad++; $display("FAIL tag9_commit v=%b data=%h idx=%0d want 01,99,19", commit_valid, commit_data[63:0], commit_idx[4:0]);
        end
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL same_tag_empty got=%0b want=1", empty); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; set_idle(); tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 2'b11; alloc_has_dest = 2'b11; alloc_idx = {5'(i+20), 5'(i)};
            tick();
        end
        set_idle();
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd0}; wb_except = 2'b01; wb_data = {64'h0, 64'hE};
        tick(); set_idle();
        total++; if (alloc_ready !== 1'b0 || empty !== 1'b0) begin bad++; $display("FAIL rstmid_pending rdy=%0b empty=%0b want 0,0", alloc_ready, empty); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (empty !== 1'b1 || recover !== 1'b0 || alloc_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_after empty=%0b rec=%0b rdy=%0b want 1,0,1", empty, recover, alloc_ready);
        end
    endtask

    task automatic test_random();
        int n;
        logic [COMMIT_W-1:0] exp_cv;
        rst_n = 1'b0; set_idle(); tick(); rst_n = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n = m_nret();
            exp_cv = '0;
            for (int c = 0; c < n; c++) exp_cv[c] = mq[c].has_dest;
            total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty cyc=%0d got=%0b want=%0b", cyc, empty, mq.size() == 0); end
            total++; if (alloc_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", cyc, alloc_ready, m_ready()); end
            total++; if (recover !== m_rec) begin bad++; $display("FAIL rnd_recover cyc=%0d got=%0b want=%0b", cyc, recover, m_rec); end
            total++; if (retire_cnt !== 2'(n)) begin bad++; $display("FAIL rnd_rcnt cyc=%0d got=%0d want=%0d", cyc, retire_cnt, n); end
            total++; if (commit_valid !== exp_cv) begin bad++; $display("FAIL rnd_cvalid cyc=%0d got=%b want=%b", cyc, commit_valid, exp_cv); end
            for (int c = 0; c < n; c++) begin
                if (mq[c].has_dest) begin
                    total++;
                    if (commit_idx[c*IDX_W +: IDX_W] !== mq[c].idx || commit_data[c*DATA_W +: DATA_W] !== mq[c].data) begin
                        bad++; $display("FAIL rnd_commit cyc=%0d lane=%0d got idx=%0d data=%h want idx=%0d data=%h", cyc, c,
                                        commit_idx[c*IDX_W +: IDX_W], commit_data[c*DATA_W +: DATA_W], mq[c].idx, mq[c].data);
                    end
                end
            end
            for (int k = 0; k < ALLOC_W; k++) begin
                total++; if (alloc_tag[k*TAG_W +: TAG_W] !== 4'((m_next + k) % DEPTH)) begin
                    bad++; $display("FAIL rnd_tag cyc=%0d lane=%0d got=%0d want=%0d", cyc, k, alloc_tag[k*TAG_W +: TAG_W], (m_next + k) % DEPTH);
                end
            end
            case ($urandom_range(2))
                0: alloc_valid = 2'b00;
                1: alloc_valid = 2'b01;
                default: alloc_valid = 2'b11;
            endcase
            alloc_has_dest = 2'($urandom_range(3));
            alloc_idx      = 10'($urandom_range(1023));
            for (int p = 0; p < WB_W; p++) begin
                wb_valid[p]  = ($urandom_range(3) != 0);
                wb_except[p] = ($urandom_range(19) == 0);
                wb_data[p*DATA_W +: DATA_W] = {$urandom, $urandom};
                if ($urandom_range(3) != 0 && mq.size() > 0)
                    wb_tag[p*TAG_W +: TAG_W] = 4'(mq[$urandom_range(mq.size() - 1)].tag);
                else
                    wb_tag[p*TAG_W +: TAG_W] = 4'($urandom_range(DEPTH - 1));
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_wrap();
        test_no_dest();
        test_except();
        test_same_tag();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
